// File: rtl/lcd_watch_pkg.sv
// Shared constants for the watch LCD receive path: segment patterns, BCD codes
// and the receiver state encoding.
package lcd_watch_pkg;

  // Segment order is {a,b,c,d,e,f,g}, MSB = a.
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [3:0] BCD_BLANK   = 4'hF;
  localparam logic [3:0] BCD_INVALID = 4'hE;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PUBLISH = 2'd2
  } state_e;

endpackage

// File: rtl/lcd_seg_to_bcd.sv
// Combinational 7-segment to BCD decoder; blank and unknown patterns raise err_o.
module lcd_seg_to_bcd
  import lcd_watch_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] bcd_o,
  output logic       err_o
);

  always_comb begin
    bcd_o = BCD_INVALID;
    err_o = 1'b1;
    case (seg_i)
      SEG_0:     begin bcd_o = 4'd0; err_o = 1'b0; end
      SEG_1:     begin bcd_o = 4'd1; err_o = 1'b0; end
      SEG_2:     begin bcd_o = 4'd2; err_o = 1'b0; end
      SEG_3:     begin bcd_o = 4'd3; err_o = 1'b0; end
      SEG_4:     begin bcd_o = 4'd4; err_o = 1'b0; end
      SEG_5:     begin bcd_o = 4'd5; err_o = 1'b0; end
      SEG_6:     begin bcd_o = 4'd6; err_o = 1'b0; end
      SEG_7:     begin bcd_o = 4'd7; err_o = 1'b0; end
      SEG_8:     begin bcd_o = 4'd8; err_o = 1'b0; end
      SEG_9:     begin bcd_o = 4'd9; err_o = 1'b0; end
      SEG_BLANK: begin bcd_o = BCD_BLANK; err_o = 1'b1; end
      default:   ;
    endcase
  end

endmodule

// File: rtl/lcd_watch_segment_receiver.sv
// Receives strobed LCD bytes, decodes digits and publishes whole frames atomically.
// Optional error statistics port ERR_COUNT is enabled by LCD_WATCH_RX_STATS_EN.
module lcd_watch_segment_receiver
  import lcd_watch_pkg::*;
#(
  parameter int NUM_DIGITS  = 6,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                    CLK,
  input  logic                    RESETN,
  input  logic [7:0]              LCD_DATA,
  input  logic                    LCD_EN,
  output logic [4*NUM_DIGITS-1:0] DIGITS,
  output logic                    FRAME_VALID,
  output logic                    FRAME_ERR,
  output logic                    BUSY
`ifdef LCD_WATCH_RX_STATS_EN
  ,
  output logic [7:0]              ERR_COUNT
`endif
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYC);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [4*NUM_DIGITS-1:0] ALL_BLANK = {NUM_DIGITS{BCD_BLANK}};

  logic [2:0]              en_sync_q;
  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [TO_W-1:0]         to_q, to_d;
  logic                    err_acc_q, err_acc_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic                    frame_err_q, frame_err_d;

  logic       fall;
  logic       rs;
  logic [3:0] dec_bcd;
  logic       dec_err;
  logic       timeout_hit;

  // en_sync_q[1] is the synchronised strobe, en_sync_q[2] its previous value.
  assign fall        = ~en_sync_q[1] & en_sync_q[2];
  assign rs          = LCD_DATA[0];
  assign timeout_hit = (state_q == COLLECT) && !fall && (to_q >= TO_LAST);

  lcd_seg_to_bcd u_dec (
    .seg_i (LCD_DATA[7:1]),
    .bcd_o (dec_bcd),
    .err_o (dec_err)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    to_d        = to_q;
    err_acc_d   = err_acc_q;
    shadow_d    = shadow_q;
    digits_d    = digits_q;
    frame_err_d = frame_err_q;
    case (state_q)
      IDLE, PUBLISH: begin
        state_d = IDLE;
        if (fall && !rs) begin
          state_d   = COLLECT;
          idx_d     = '0;
          err_acc_d = 1'b0;
          to_d      = '0;
        end
      end
      COLLECT: begin
        if (fall) begin
          to_d = '0;
          if (!rs) begin
            idx_d     = '0;
            err_acc_d = 1'b0;
          end else begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
              if (idx_q == IDX_W'(k)) shadow_d[4*(NUM_DIGITS-k)-1 -: 4] = dec_bcd;
            end
            err_acc_d = err_acc_q | dec_err;
            if (idx_q == LAST_IDX) begin
              // Load the outputs on entry so DIGITS is already new while FRAME_VALID is high.
              state_d     = PUBLISH;
              idx_d       = '0;
              digits_d    = shadow_d;
              frame_err_d = err_acc_d;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end else if (timeout_hit) begin
          state_d = IDLE;
          to_d    = '0;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      en_sync_q   <= '0;
      state_q     <= IDLE;
      idx_q       <= '0;
      to_q        <= '0;
      err_acc_q   <= 1'b0;
      shadow_q    <= ALL_BLANK;
      digits_q    <= ALL_BLANK;
      frame_err_q <= 1'b0;
    end else begin
      en_sync_q   <= {en_sync_q[1:0], LCD_EN};
      state_q     <= state_d;
      idx_q       <= idx_d;
      to_q        <= to_d;
      err_acc_q   <= err_acc_d;
      shadow_q    <= shadow_d;
      digits_q    <= digits_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign DIGITS      = digits_q;
  assign FRAME_ERR   = frame_err_q;
  assign FRAME_VALID = (state_q == PUBLISH);
  assign BUSY        = (state_q == COLLECT);

`ifdef LCD_WATCH_RX_STATS_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      err_cnt_q <= 8'h00;
    end else if (((state_q == PUBLISH) && frame_err_q) || timeout_hit) begin
      if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'h01;
    end
  end

  assign ERR_COUNT = err_cnt_q;
`endif

endmodule

// File: tb/tb_lcd_watch_segment_receiver.sv
// Bench for lcd_watch_segment_receiver: expected frames are queued when strobed
// and compared when FRAME_VALID pulses.
module tb_lcd_watch_segment_receiver;

  localparam int N  = 6;
  localparam int TO = 1000;
  localparam int FW = 4*N + 1;

  logic         CLK;
  logic         RESETN;
  logic [7:0]   LCD_DATA;
  logic         LCD_EN;
  logic [4*N-1:0] DIGITS;
  logic         FRAME_VALID;
  logic         FRAME_ERR;
  logic         BUSY;
`ifdef LCD_WATCH_RX_STATS_EN
  logic [7:0]   ERR_COUNT;
`endif

  lcd_watch_segment_receiver #(.NUM_DIGITS(N), .TIMEOUT_CYC(TO)) dut (
    .CLK         (CLK),
    .RESETN      (RESETN),
    .LCD_DATA    (LCD_DATA),
    .LCD_EN      (LCD_EN),
    .DIGITS      (DIGITS),
    .FRAME_VALID (FRAME_VALID),
    .FRAME_ERR   (FRAME_ERR),
    .BUSY        (BUSY)
`ifdef LCD_WATCH_RX_STATS_EN
    ,
    .ERR_COUNT   (ERR_COUNT)
`endif
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  int valid_cnt = 0;
  int last_valid_cyc = 0;
  int last_fall_cyc  = 0;
  logic prev_valid = 1'b0;
  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] last_exp;

  // Independent reference decoder: {bcd, err}.
  function automatic logic [4:0] ref_decode(input logic [6:0] s);
    case (s)
      7'b1111110: ref_decode = {4'd0, 1'b0};
      7'b0110000: ref_decode = {4'd1, 1'b0};
      7'b1101101: ref_decode = {4'd2, 1'b0};
      7'b1111001: ref_decode = {4'd3, 1'b0};
      7'b0110011: ref_decode = {4'd4, 1'b0};
      7'b1011011: ref_decode = {4'd5, 1'b0};
      7'b1011111: ref_decode = {4'd6, 1'b0};
      7'b1110000: ref_decode = {4'd7, 1'b0};
      7'b1111111: ref_decode = {4'd8, 1'b0};
      7'b1111011: ref_decode = {4'd9, 1'b0};
      7'b0000000: ref_decode = {4'hF, 1'b1};
      default:    ref_decode = {4'hE, 1'b1};
    endcase
  endfunction

  function automatic logic [FW-1:0] frame_exp(input logic [8*N-1:0] b);
    logic [4:0] r;
    frame_exp = '0;
    for (int k = 0; k < N; k++) begin
      r = ref_decode(b[8*N-1-8*k -: 7]);
      frame_exp[4*N-1-4*k -: 4] = r[4:1];
      frame_exp[FW-1] = frame_exp[FW-1] | r[0];
    end
  endfunction

  // scoreboard monitor
  always @(negedge CLK) begin
    if (RESETN && FRAME_VALID) begin
      logic [FW-1:0] e;
      valid_cnt++;
      last_valid_cyc = cyc;
      n_checks++;
      if (prev_valid) $display("FAIL valid_width: FRAME_VALID high on two consecutive cycles (got 2 want 1)");
      else n_pass++;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_frame: got %h with empty queue", {FRAME_ERR, DIGITS});
      end else begin
        e = exp_q.pop_front();
        if ({FRAME_ERR, DIGITS} !== e) $display("FAIL frame: got err=%b digits=%h want err=%b digits=%h",
                                                FRAME_ERR, DIGITS, e[FW-1], e[4*N-1:0]);
        else n_pass++;
      end
    end
    prev_valid = RESETN && FRAME_VALID;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    LCD_DATA = d;
    LCD_EN   = 1'b1;
    wait_cyc(3);
    LCD_EN   = 1'b0;
    last_fall_cyc = cyc;
    wait_cyc(4);
  endtask

  task automatic send_frame(input logic [8*N-1:0] b, input bit with_cmd);
    logic [FW-1:0] e;
    int v0;
    e = frame_exp(b);
    if (with_cmd) send_byte(8'h00);
    n_checks++;
    if (BUSY !== 1'b1) $display("FAIL busy_collect: got %b want 1", BUSY); else n_pass++;
    v0 = valid_cnt;
    for (int k = 0; k < N; k++) begin
      if (k == N-1) begin
        exp_q.push_back(e);
        last_exp = e;
      end
      send_byte(b[8*N-1-8*k -: 8]);
    end
    n_checks++;
    if (valid_cnt !== v0 + 1) $display("FAIL valid_count: got %0d want %0d", valid_cnt - v0, 1); else n_pass++;
    n_checks++;
    if (BUSY !== 1'b0) $display("FAIL busy_after: got %b want 0", BUSY); else n_pass++;
    n_checks++;
    if ((last_valid_cyc - last_fall_cyc) < 1 || (last_valid_cyc - last_fall_cyc) > 4)
      $display("FAIL latency: got %0d want 1..4", last_valid_cyc - last_fall_cyc);
    else n_pass++;
  endtask

  // scenarios
  task automatic test_reset();
    RESETN = 1'b0; LCD_EN = 1'b0; LCD_DATA = 8'h00;
    wait_cyc(3);
    #2 RESETN = 1'b1;
    wait_cyc(2);
    n_checks++;
    if ({DIGITS, FRAME_VALID, FRAME_ERR, BUSY} !== {{N{4'hF}}, 3'b000})
      $display("FAIL reset_values: got %h/%b/%b/%b want ffffff/0/0/0", DIGITS, FRAME_VALID, FRAME_ERR, BUSY);
    else n_pass++;
`ifdef LCD_WATCH_RX_STATS_EN
    n_checks++;
    if (ERR_COUNT !== 8'h00) $display("FAIL reset_err_count: got %h want 00", ERR_COUNT); else n_pass++;
`endif
  endtask

  task automatic test_basic();
    send_frame(48'h61DBF367B7F7, 1'b1);
  endtask

  task automatic test_invalid();
    send_frame(48'h61DB0367B7F7, 1'b1);
`ifdef LCD_WATCH_RX_STATS_EN
    n_checks++;
    if (ERR_COUNT !== 8'h01) $display("FAIL err_count_invalid: got %h want 01", ERR_COUNT); else n_pass++;
`endif
  endtask

  task automatic test_blank_restart();
    int v0;
    v0 = valid_cnt;
    send_byte(8'h00);
    send_byte(8'h61);
    send_byte(8'hDB);
    send_byte(8'h00);
    n_checks++;
    if (BUSY !== 1'b1 || valid_cnt !== v0) $display("FAIL restart: got busy=%b frames=%0d want busy=1 frames=0", BUSY, valid_cnt - v0);
    else n_pass++;
    send_frame(48'h61DBF301B7F7, 1'b0);
`ifdef LCD_WATCH_RX_STATS_EN
    n_checks++;
    if (ERR_COUNT !== 8'h02) $display("FAIL err_count_blank: got %h want 02", ERR_COUNT); else n_pass++;
`endif
  endtask

  task automatic test_timeout();
    int v0;
    v0 = valid_cnt;
    send_byte(8'h00);
    send_byte(8'hFD);
    send_byte(8'hE1);
    send_byte(8'hFF);
    wait_cyc(TO - 20);
    n_checks++;
    if (BUSY !== 1'b1) $display("FAIL busy_before_timeout: got %b want 1", BUSY); else n_pass++;
    wait_cyc(25);
    n_checks++;
    if (BUSY !== 1'b0) $display("FAIL busy_after_timeout: got %b want 0", BUSY); else n_pass++;
    n_checks++;
    if (valid_cnt !== v0) $display("FAIL timeout_no_frame: got %0d want 0", valid_cnt - v0); else n_pass++;
    n_checks++;
    if ({FRAME_ERR, DIGITS} !== last_exp) $display("FAIL timeout_hold: got %h want %h", {FRAME_ERR, DIGITS}, last_exp);
    else n_pass++;
`ifdef LCD_WATCH_RX_STATS_EN
    n_checks++;
    if (ERR_COUNT !== 8'h03) $display("FAIL err_count_timeout: got %h want 03", ERR_COUNT); else n_pass++;
`endif
  endtask

  task automatic test_idle_ignore();
    int v0;
    v0 = valid_cnt;
    for (int i = 0; i < 3; i++) begin
      send_byte({7'($urandom_range(0, 127)), 1'b1});
      n_checks++;
      if (BUSY !== 1'b0) $display("FAIL idle_ignore_busy: got %b want 0", BUSY); else n_pass++;
    end
    n_checks++;
    if (valid_cnt !== v0 || {FRAME_ERR, DIGITS} !== last_exp)
      $display("FAIL idle_ignore_out: got %h frames=%0d want %h frames=0", {FRAME_ERR, DIGITS}, valid_cnt - v0, last_exp);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [8*N-1:0] a;
    int v0;
    a  = 48'hFDE1FFBF61DB;
    v0 = valid_cnt;
    send_byte(8'h00);
    for (int k = 0; k < N-1; k++) send_byte(a[8*N-1-8*k -: 8]);
    exp_q.push_back(frame_exp(a));
    // Last digit, then the next command strobe as close as the synchroniser allows.
    LCD_DATA = a[7:0];
    LCD_EN = 1'b1;
    wait_cyc(3);
    LCD_EN = 1'b0;
    last_fall_cyc = cyc;
    wait_cyc(1);
    LCD_EN = 1'b1;
    wait_cyc(1);
    LCD_EN = 1'b0;
    wait_cyc(1);
    LCD_DATA = 8'h00;
    wait_cyc(4);
    n_checks++;
    if (valid_cnt !== v0 + 1) $display("FAIL b2b_first: got %0d want 1", valid_cnt - v0); else n_pass++;
    send_frame(48'hF7B767F3DB61, 1'b0);
    n_checks++;
    if (valid_cnt !== v0 + 2) $display("FAIL b2b_both: got %0d want 2", valid_cnt - v0); else n_pass++;
  endtask

  task automatic test_reset_mid();
    send_byte(8'h00);
    send_byte(8'h61);
    send_byte(8'hDB);
    #3 RESETN = 1'b0;
    #1;
    n_checks++;
    if ({DIGITS, FRAME_VALID, FRAME_ERR, BUSY} !== {{N{4'hF}}, 3'b000})
      $display("FAIL async_reset: got %h/%b/%b/%b want ffffff/0/0/0", DIGITS, FRAME_VALID, FRAME_ERR, BUSY);
    else n_pass++;
`ifdef LCD_WATCH_RX_STATS_EN
    n_checks++;
    if (ERR_COUNT !== 8'h00) $display("FAIL async_reset_err_count: got %h want 00", ERR_COUNT); else n_pass++;
`endif
    wait_cyc(2);
    #2 RESETN = 1'b1;
    wait_cyc(2);
    send_frame(48'hB7F7FD61E1BF, 1'b1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_invalid();
    test_blank_restart();
    test_timeout();
    test_idle_ignore();
    test_back_to_back();
    test_reset_mid();
    wait_cyc(5);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL queue_drain: got %0d pending want 0", exp_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
